// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the fetch PC, runs the request/ready
// handshake with instruction memory and holds the IF/ID pipeline register.
// A one-entry skid buffer catches a fetch that completes while decode is
// stalled, and a pending-redirect register remembers a taken branch that
// arrives while a request is still waiting for IReady.
//
// Ports
//   Clk          in   clock, rising edge
//   Rst          in   asynchronous active-high reset
//   Stall        in   hazard unit: IF/ID must hold
//   Taken        in   branch unit resolved a taken branch/jump this cycle
//   BranchTarget in   redirect address (low two bits ignored)
//   IReq         out  fetch request to instruction memory
//   IAddr        out  fetch address
//   IReady       in   memory accepts the request and returns IData
//   IData        in   fetched instruction
//   InstrOut     out  IF/ID instruction
//   PCOut        out  IF/ID PC
//   PCPlus4Out   out  IF/ID PC + 4
//   InstrValid   out  IF/ID holds a real instruction
module fetch_stage #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Stall,
    input  logic         Taken,
    input  logic [N-1:0] BranchTarget,
    output logic         IReq,
    output logic [N-1:0] IAddr,
    input  logic         IReady,
    input  logic [31:0]  IData,
    output logic [31:0]  InstrOut,
    output logic [N-1:0] PCOut,
    output logic [N-1:0] PCPlus4Out,
    output logic         InstrValid
);

    localparam logic [31:0]  NOP        = 32'h00000013;
    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};
    localparam logic [N-1:0] FOUR       = N'(4);

    logic [N-1:0] fetch_pc_reg;
    logic [N-1:0] redir_pc_reg;
    logic         pend_reg;
    logic         skid_valid_reg;
    logic [31:0]  skid_instr_reg;
    logic [N-1:0] skid_pc_reg;
    logic [31:0]  instr_reg;
    logic [N-1:0] pc_reg;
    logic [N-1:0] pc_plus4_reg;
    logic         valid_reg;

    logic [N-1:0] target;
    logic         accept;
    logic         keep;

    // Request is combinational in Rst so that a reset in the middle of a
    // handshake withdraws it immediately rather than at the next edge.
    assign IReq   = !Rst && !skid_valid_reg;
    assign IAddr  = fetch_pc_reg;
    assign target = BranchTarget & ALIGN_MASK;
    assign accept = IReq && IReady;
    // An accepted word is only useful if no redirect kills it: either one
    // arriving now or one that was parked while this request waited.
    assign keep   = accept && !Taken && !pend_reg;

    assign InstrOut   = instr_reg;
    assign PCOut      = pc_reg;
    assign PCPlus4Out = pc_plus4_reg;
    assign InstrValid = valid_reg;

    // Fetch PC and pending redirect.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_pc_reg <= RESET_PC;
            redir_pc_reg <= '0;
            pend_reg     <= 1'b0;
        end else if (Taken && IReq && !IReady) begin
            // Cannot retract a live request: park the target until accept.
            pend_reg     <= 1'b1;
            redir_pc_reg <= target;
        end else if (Taken) begin
            fetch_pc_reg <= target;
            pend_reg     <= 1'b0;
        end else if (accept && pend_reg) begin
            fetch_pc_reg <= redir_pc_reg;
            pend_reg     <= 1'b0;
        end else if (accept) begin
            fetch_pc_reg <= fetch_pc_reg + FOUR;
        end
    end

    // IF/ID register and skid entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= NOP;
            skid_pc_reg    <= '0;
            instr_reg      <= NOP;
            pc_reg         <= '0;
            pc_plus4_reg   <= '0;
            valid_reg      <= 1'b0;
        end else if (Taken) begin
            valid_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (Stall) begin
            if (keep) begin
                skid_valid_reg <= 1'b1;
                skid_instr_reg <= IData;
                skid_pc_reg    <= fetch_pc_reg;
            end
        end else if (skid_valid_reg) begin
            // IReq is low while the skid is full, so no accept competes here.
            skid_valid_reg <= 1'b0;
            instr_reg      <= skid_instr_reg;
            pc_reg         <= skid_pc_reg;
            pc_plus4_reg   <= skid_pc_reg + FOUR;
            valid_reg      <= 1'b1;
        end else if (keep) begin
            instr_reg      <= IData;
            pc_reg         <= fetch_pc_reg;
            pc_plus4_reg   <= fetch_pc_reg + FOUR;
            valid_reg      <= 1'b1;
        end else begin
            instr_reg      <= NOP;
            valid_reg      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table covering the fetch,
// stall/skid, redirect, pending-redirect and address-wrap cases, an
// asynchronous mid-request reset check, then randomized traffic compared
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h00000100;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Taken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IReady = 1'b0;
    logic [31:0] IData = '0;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4Out;
    logic        InstrValid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.N(32), .RESET_PC(RPC)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Taken(Taken),
        .BranchTarget(BranchTarget), .IReq(IReq), .IAddr(IAddr),
        .IReady(IReady), .IData(IData), .InstrOut(InstrOut),
        .PCOut(PCOut), .PCPlus4Out(PCPlus4Out), .InstrValid(InstrValid)
    );

    always #5 Clk = ~Clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h12345678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        taken;
        logic [31:0] target;
        logic        ready;
        logic        exp_ireq;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic t, input logic [31:0] tg,
                                input logic r, input logic eq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.taken = t; v.target = tg; v.ready = r;
        v.exp_ireq = eq; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    // Behavioural model state.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        q_skid[$];
    logic [31:0] m_pc, m_redir, m_instr, m_pcout, m_pc4;
    logic        m_pend, m_valid;

    task automatic model_reset();
        q_skid.delete();
        m_pc = RPC; m_redir = '0; m_pend = 1'b0;
        m_instr = NOP; m_pcout = '0; m_pc4 = '0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic [31:0] tg,
                              input logic r, input logic [31:0] d);
        logic        req, acc, use_it;
        logic [31:0] tgt, old_pc;
        ent_t        e;
        req    = (q_skid.size() == 0);
        acc    = req && r;
        tgt    = {tg[31:2], 2'b00};
        old_pc = m_pc;
        use_it = acc && !t && !m_pend;
        if (t && req && !r) begin
            m_pend = 1'b1; m_redir = tgt;
        end else if (t) begin
            m_pc = tgt; m_pend = 1'b0;
        end else if (acc && m_pend) begin
            m_pc = m_redir; m_pend = 1'b0;
        end else if (acc) begin
            m_pc = old_pc + 32'd4;
        end
        if (t) begin
            m_valid = 1'b0;
            q_skid.delete();
        end else if (s) begin
            if (use_it) begin
                e.instr = d; e.pc = old_pc;
                q_skid.push_back(e);
            end
        end else if (q_skid.size() != 0) begin
            e = q_skid.pop_front();
            m_instr = e.instr; m_pcout = e.pc; m_pc4 = e.pc + 32'd4; m_valid = 1'b1;
        end else if (use_it) begin
            m_instr = d; m_pcout = old_pc; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
        end else begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endtask

    vec_t tbl[25];

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,        1, 1, 32'h104,      1, 32'h100);
        tbl[2]  = mk(1, 0, 32'h0,        1, 1, 32'h108,      1, 32'h104);
        tbl[3]  = mk(1, 0, 32'h0,        1, 0, 32'h10C,      1, 32'h104);
        tbl[4]  = mk(1, 0, 32'h0,        1, 0, 32'h10C,      1, 32'h104);
        tbl[5]  = mk(0, 0, 32'h0,        1, 0, 32'h10C,      1, 32'h104);
        tbl[6]  = mk(0, 0, 32'h0,        1, 1, 32'h10C,      1, 32'h108);
        tbl[7]  = mk(0, 1, 32'h203,      1, 1, 32'h110,      1, 32'h10C);
        tbl[8]  = mk(0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0);
        tbl[9]  = mk(0, 0, 32'h0,        1, 1, 32'h204,      1, 32'h200);
        tbl[10] = mk(0, 0, 32'h0,        0, 1, 32'h208,      1, 32'h204);
        tbl[11] = mk(0, 1, 32'h400,      0, 1, 32'h208,      0, 32'h0);
        tbl[12] = mk(0, 1, 32'h502,      0, 1, 32'h208,      0, 32'h0);
        tbl[13] = mk(0, 0, 32'h0,        0, 1, 32'h208,      0, 32'h0);
        tbl[14] = mk(0, 0, 32'h0,        1, 1, 32'h208,      0, 32'h0);
        tbl[15] = mk(0, 0, 32'h0,        1, 1, 32'h500,      0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,        1, 1, 32'h504,      1, 32'h500);
        tbl[17] = mk(1, 0, 32'h0,        0, 1, 32'h508,      1, 32'h504);
        tbl[18] = mk(1, 0, 32'h0,        1, 1, 32'h508,      1, 32'h504);
        tbl[19] = mk(1, 1, 32'h300,      1, 0, 32'h50C,      1, 32'h504);
        tbl[20] = mk(0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h0);
        tbl[21] = mk(0, 0, 32'h0,        1, 1, 32'h304,      1, 32'h300);
        tbl[22] = mk(0, 1, 32'hFFFFFFFC, 1, 1, 32'h308,      1, 32'h304);
        tbl[23] = mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 0, 32'h0);
        tbl[24] = mk(0, 0, 32'h0,        1, 1, 32'h00000000, 1, 32'hFFFFFFFC);

        // Reset state while Rst is held.
        @(posedge Clk); @(negedge Clk);
        chk("rst_ireq",  {31'd0, IReq},       32'd0);
        chk("rst_iaddr", IAddr,               RPC);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_instr", InstrOut,            NOP);
        chk("rst_pc",    PCOut,               32'd0);
        chk("rst_pc4",   PCPlus4Out,          32'd0);
        Rst = 1'b0;

        // Directed vectors: inputs applied at negedge, outputs sampled 2 units later.
        for (int i = 0; i < 25; i++) begin
            Stall = tbl[i].stall; Taken = tbl[i].taken;
            BranchTarget = tbl[i].target; IReady = tbl[i].ready;
            IData = mem_word(tbl[i].exp_addr);
            #2;
            $display("[TB] vec %0d stall=%0d taken=%0d ready=%0d ireq=%0d iaddr=%h valid=%0d pc=%h",
                     i, Stall, Taken, IReady, IReq, IAddr, InstrValid, PCOut);
            chk($sformatf("v%0d_ireq", i),  {31'd0, IReq},       {31'd0, tbl[i].exp_ireq});
            chk($sformatf("v%0d_iaddr", i), IAddr,               tbl[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, InstrValid}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i),    PCOut,      tbl[i].exp_pc);
                chk($sformatf("v%0d_pc4", i),   PCPlus4Out, tbl[i].exp_pc + 32'd4);
                chk($sformatf("v%0d_instr", i), InstrOut,   mem_word(tbl[i].exp_pc));
            end
            @(posedge Clk); @(negedge Clk);
        end

        // Reset in the middle of an outstanding request: everything drops at once.
        Stall = 1'b0; Taken = 1'b0; IReady = 1'b0;
        #2;
        chk("mid_ireq_before", {31'd0, IReq}, 32'd1);
        Rst = 1'b1;
        #1;
        $display("[TB] mid-request reset ireq=%0d iaddr=%h valid=%0d", IReq, IAddr, InstrValid);
        chk("mid_rst_ireq",  {31'd0, IReq},       32'd0);
        chk("mid_rst_iaddr", IAddr,               RPC);
        chk("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("mid_rst_instr", InstrOut,            NOP);
        chk("mid_rst_pc",    PCOut,               32'd0);
        chk("mid_rst_pc4",   PCPlus4Out,          32'd0);
        @(posedge Clk); @(negedge Clk);
        Rst = 1'b0;
        model_reset();

        // Randomized traffic against the behavioural model.
        for (int c = 0; c < 3000; c++) begin
            logic        s, t, r;
            logic [31:0] tg;
            s  = ($urandom_range(0, 9) < 3);
            t  = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 9) < 7);
            tg = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            Stall = s; Taken = t; BranchTarget = tg; IReady = r;
            IData = mem_word(m_pc);
            #2;
            chk($sformatf("r%0d_ireq", c),  {31'd0, IReq},       {31'd0, q_skid.size() == 0});
            chk($sformatf("r%0d_iaddr", c), IAddr,               m_pc);
            chk($sformatf("r%0d_valid", c), {31'd0, InstrValid}, {31'd0, m_valid});
            chk($sformatf("r%0d_instr", c), InstrOut,            m_instr);
            if (m_valid) begin
                chk($sformatf("r%0d_pc", c),  PCOut,      m_pcout);
                chk($sformatf("r%0d_pc4", c), PCPlus4Out, m_pc4);
            end
            @(posedge Clk);
            model_step(s, t, tg, r, IData);
            @(negedge Clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
